// File: rtl/user_rq_arbiter.sv
// user_rq_arbiter: merges NUM_CH requester-request AXI-S streams into one.
// Each channel buffers beats in its own FIFO. Only whole packets (a stored
// tlast) are offered for arbitration. Grants rotate round-robin, and a
// granted packet is forwarded without interleaving from other channels.
module user_rq_arbiter #(
  parameter int NUM_CH              = 4,
  parameter int FIFO_DEPTH          = 16,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62
) (
  input  logic                                  user_clk,
  input  logic                                  reset,
  input  logic                                  user_lnk_up,
  input  logic [NUM_CH*C_DATA_WIDTH-1:0]        wr_s_axis_rq_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0]          wr_s_axis_rq_tkeep,
  input  logic [NUM_CH*AXI4_RQ_TUSER_WIDTH-1:0] wr_s_axis_rq_tuser,
  input  logic [NUM_CH-1:0]                     wr_s_axis_rq_tlast,
  input  logic [NUM_CH-1:0]                     wr_s_axis_rq_tvalid,
  output logic [NUM_CH-1:0]                     wr_s_axis_rq_tready,
  output logic [C_DATA_WIDTH-1:0]               s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]                 s_axis_rq_tkeep,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]        s_axis_rq_tuser,
  output logic                                  s_axis_rq_tlast,
  output logic                                  s_axis_rq_tvalid,
  input  logic                                  s_axis_rq_tready,
  output logic [NUM_CH-1:0]                     ch_full,
  output logic [NUM_CH-1:0]                     ch_ovf_err,
  output logic [2:0]                            grant_ch
);

  localparam int BEAT_W = C_DATA_WIDTH + KEEP_WIDTH + AXI4_RQ_TUSER_WIDTH + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [2:0]        gnt_nxt, rr_ptr, rr_nxt, pick, cand;
  logic              found;
  logic              pop_any;
  logic              head_last;
  logic [7:0]        eligible;
  // Padded to 8 entries so a 3-bit grant index always selects a defined slot.
  logic [BEAT_W-1:0] head [8];
  logic [BEAT_W-1:0] out_beat;

  assign pop_any   = (state == SEND) && s_axis_rq_tready;
  assign head_last = head[grant_ch][0];

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_fifo
      logic [BEAT_W-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     wr_ptr, rd_ptr;
      logic [CW-1:0]     cnt, pkt_cnt;
      logic              full, flush, wr_en, rd_en, wr_last, rd_last, ovf;

      assign full    = (cnt == CW'(FIFO_DEPTH));
      // A full FIFO with no complete packet can never drain: drop it.
      assign flush   = full && (pkt_cnt == '0);
      assign wr_en   = wr_s_axis_rq_tvalid[i] && !full;
      assign rd_en   = pop_any && (grant_ch == 3'(i));
      assign wr_last = wr_en && wr_s_axis_rq_tlast[i];
      assign rd_last = rd_en && mem[rd_ptr][0];

      assign head[i]                = mem[rd_ptr];
      assign eligible[i]            = (pkt_cnt != '0);
      assign ch_full[i]             = full;
      assign wr_s_axis_rq_tready[i] = !full;
      assign ch_ovf_err[i]          = ovf;

      // FIFO pointers, beat/packet occupancy and sticky overflow flag
      always_ff @(posedge user_clk) begin
        if (reset) begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          cnt     <= '0;
          pkt_cnt <= '0;
          ovf     <= 1'b0;
        end else if (flush) begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          cnt     <= '0;
          ovf     <= 1'b1;
        end else begin
          if (wr_en) wr_ptr <= wr_ptr + AW'(1);
          if (rd_en) rd_ptr <= rd_ptr + AW'(1);
          cnt     <= cnt + CW'(wr_en) - CW'(rd_en);
          pkt_cnt <= pkt_cnt + CW'(wr_last) - CW'(rd_last);
        end
      end

      // Beat storage; contents are don't-care until covered by the pointers
      always_ff @(posedge user_clk) begin
        if (wr_en) begin
          mem[wr_ptr] <= {wr_s_axis_rq_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH],
                          wr_s_axis_rq_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                          wr_s_axis_rq_tuser[i*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH],
                          wr_s_axis_rq_tlast[i]};
        end
      end
    end else begin : g_pad
      assign eligible[i] = 1'b0;
      assign head[i]     = '0;
    end
  end

  // Round-robin pick: first eligible channel at or after rr_ptr
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = 3'((int'(rr_ptr) + k) % NUM_CH);
      if (eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_ch <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_ch <= gnt_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  // Next-state: grant in IDLE, release after the last beat is accepted
  always_comb begin
    state_nxt = state;
    gnt_nxt   = grant_ch;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (user_lnk_up && found) begin
          state_nxt = SEND;
          gnt_nxt   = pick;
        end
      end
      SEND: begin
        if (pop_any && head_last) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          rr_nxt    = (grant_ch == 3'(NUM_CH - 1)) ? 3'd0 : grant_ch + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: FIFO head of the granted channel while sending, zero otherwise
  always_comb begin
    out_beat         = '0;
    s_axis_rq_tvalid = 1'b0;
    if (state == SEND) begin
      s_axis_rq_tvalid = 1'b1;
      out_beat         = head[grant_ch];
    end
  end

  assign {s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tuser, s_axis_rq_tlast} = out_beat;

endmodule

// File: tb/tb_user_rq_arbiter.sv
// Testbench for user_rq_arbiter. The stimulus pushes the expected output
// beats into a scoreboard queue, and a negedge monitor pops and compares
// every accepted beat. A second small instance (FIFO_DEPTH=4) covers the
// overflow behaviour.
module tb_user_rq_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 128;
  localparam int KW  = 4;
  localparam int UW  = 62;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, lnk;
  logic [NCH*DW-1:0] wr_tdata;
  logic [NCH*KW-1:0] wr_tkeep;
  logic [NCH*UW-1:0] wr_tuser;
  logic [NCH-1:0]    wr_tlast, wr_tvalid, wr_tready, ch_full, ch_ovf;
  logic [DW-1:0]     tdata;
  logic [KW-1:0]     tkeep;
  logic [UW-1:0]     tuser;
  logic              tlast, tvalid, tready;
  logic [2:0]        grant;

  logic [2*DW-1:0]   b_wr_tdata;
  logic [2*KW-1:0]   b_wr_tkeep;
  logic [2*UW-1:0]   b_wr_tuser;
  logic [1:0]        b_wr_tlast, b_wr_tvalid, b_wr_tready, b_ch_full, b_ovf;
  logic [DW-1:0]     b_tdata;
  logic [KW-1:0]     b_tkeep;
  logic [UW-1:0]     b_tuser;
  logic              b_tlast, b_tvalid;
  logic [2:0]        b_grant;

  user_rq_arbiter #(.NUM_CH(NCH), .FIFO_DEPTH(16), .C_DATA_WIDTH(DW),
                    .KEEP_WIDTH(KW), .AXI4_RQ_TUSER_WIDTH(UW)) dut (
    .user_clk(clk), .reset(reset), .user_lnk_up(lnk),
    .wr_s_axis_rq_tdata(wr_tdata), .wr_s_axis_rq_tkeep(wr_tkeep),
    .wr_s_axis_rq_tuser(wr_tuser), .wr_s_axis_rq_tlast(wr_tlast),
    .wr_s_axis_rq_tvalid(wr_tvalid), .wr_s_axis_rq_tready(wr_tready),
    .s_axis_rq_tdata(tdata), .s_axis_rq_tkeep(tkeep), .s_axis_rq_tuser(tuser),
    .s_axis_rq_tlast(tlast), .s_axis_rq_tvalid(tvalid), .s_axis_rq_tready(tready),
    .ch_full(ch_full), .ch_ovf_err(ch_ovf), .grant_ch(grant));

  user_rq_arbiter #(.NUM_CH(2), .FIFO_DEPTH(4), .C_DATA_WIDTH(DW),
                    .KEEP_WIDTH(KW), .AXI4_RQ_TUSER_WIDTH(UW)) dut_small (
    .user_clk(clk), .reset(reset), .user_lnk_up(1'b1),
    .wr_s_axis_rq_tdata(b_wr_tdata), .wr_s_axis_rq_tkeep(b_wr_tkeep),
    .wr_s_axis_rq_tuser(b_wr_tuser), .wr_s_axis_rq_tlast(b_wr_tlast),
    .wr_s_axis_rq_tvalid(b_wr_tvalid), .wr_s_axis_rq_tready(b_wr_tready),
    .s_axis_rq_tdata(b_tdata), .s_axis_rq_tkeep(b_tkeep), .s_axis_rq_tuser(b_tuser),
    .s_axis_rq_tlast(b_tlast), .s_axis_rq_tvalid(b_tvalid), .s_axis_rq_tready(1'b1),
    .ch_full(b_ch_full), .ch_ovf_err(b_ovf), .grant_ch(b_grant));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [127:0]  side;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int ch, input int tag, input int b);
    return {4{8'(ch), 8'(tag), 8'(b), 8'hC3}};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int b, input int n);
    return (b == n - 1) ? 4'b0011 : 4'b1111;
  endfunction

  function automatic logic [UW-1:0] mk_user(input int ch, input int tag, input int b);
    return {1'b1, 61'((ch << 16) | (tag << 8) | b)};
  endfunction

  function automatic logic [127:0] side_of(input logic [2:0] g, input logic l,
                                           input logic [KW-1:0] k, input logic [UW-1:0] u);
    return 128'({g, l, k, u});
  endfunction

  // Queue the beats of one packet in the order they must leave the arbiter
  task automatic expect_pkt(input int ch, input int tag, input int n);
    for (int b = 0; b < n; b++)
      sb.push_back('{mk_data(ch, tag, b),
                     side_of(3'(ch), (b == n - 1), mk_keep(b, n), mk_user(ch, tag, b))});
  endtask

  // Write beats b0..b1-1 of a 'total'-beat packet on every channel in mask
  task automatic load(input logic [3:0] mask, input int tag, input int b0,
                      input int b1, input int total);
    logic [1:0] ci;
    for (int b = b0; b < b1; b++) begin
      for (int c = 0; c < NCH; c++) begin
        ci = 2'(c);
        if (mask[ci]) begin
          wr_tvalid[ci]          = 1'b1;
          wr_tdata[c*DW +: DW]   = mk_data(c, tag, b);
          wr_tkeep[c*KW +: KW]   = mk_keep(b, total);
          wr_tuser[c*UW +: UW]   = mk_user(c, tag, b);
          wr_tlast[ci]           = (b == total - 1);
        end
      end
      @(posedge clk); #1;
    end
    wr_tvalid = '0;
    wr_tlast  = '0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drain"}, 128'(sb.size()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare on each accepted beat, plus stall/gap rules
  logic          prev_stall, prev_last, prev_mid;
  logic [DW-1:0] prev_data;
  logic [127:0]  prev_side;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
      prev_last  <= 1'b0;
      prev_mid   <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(tvalid), 128'(1));
        chk("hold_data", 128'(tdata), 128'(prev_data));
        chk("hold_side", side_of(grant, tlast, tkeep, tuser), prev_side);
      end
      if (prev_last) chk("gap_after_last", 128'(tvalid), 128'(0));
      if (prev_mid)  chk("no_gap_in_pkt", 128'(tvalid), 128'(1));
      if (tvalid && tready) begin
        chk("beat_expected", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          chk("out_data", 128'(tdata), 128'(sb[0].data));
          chk("out_side", side_of(grant, tlast, tkeep, tuser), sb[0].side);
          void'(sb.pop_front());
        end
      end
      prev_stall <= tvalid && !tready;
      prev_data  <= tdata;
      prev_side  <= side_of(grant, tlast, tkeep, tuser);
      prev_last  <= tvalid && tready && tlast;
      prev_mid   <= tvalid && tready && !tlast;
    end
  end

  logic [15:0] stall_pat;

  initial begin
    reset = 1'b1; lnk = 1'b1; tready = 1'b1;
    wr_tdata = '0; wr_tkeep = '0; wr_tuser = '0; wr_tlast = '0; wr_tvalid = '0;
    b_wr_tdata = '0; b_wr_tkeep = '0; b_wr_tuser = '0; b_wr_tlast = '0; b_wr_tvalid = '0;
    stall_pat = 16'b0110_1001_1100_0101;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 128'(tvalid), 128'(0));
    chk("rst_tdata", 128'(tdata), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_full", 128'(ch_full), 128'(0));
    chk("rst_ovf", 128'(ch_ovf), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_tready", 128'(wr_tready), 128'(4'hF));

    // Four channels loaded together drain in index order
    for (int c = 0; c < 4; c++) expect_pkt(c, 1, 3);
    load(4'hF, 1, 0, 3, 3);
    wait_drain("rr_all");

    // Serve ch2 so the pointer sits at 3, then ch0+ch3 together -> ch3 first
    expect_pkt(2, 2, 2);
    load(4'b0100, 2, 0, 2, 2);
    wait_drain("ch2_only");
    expect_pkt(3, 3, 2);
    expect_pkt(0, 3, 2);
    load(4'b1001, 3, 0, 2, 2);
    wait_drain("rr_wrap");

    // Partial packet held back; tlast written in cycle N appears at N+2
    expect_pkt(1, 4, 3);
    load(4'b0010, 4, 0, 2, 3);
    repeat (6) @(posedge clk);
    #1;
    chk("partial_no_valid", 128'(tvalid), 128'(0));
    load(4'b0010, 4, 2, 3, 3);
    chk("latency_n1", 128'(tvalid), 128'(0));
    @(posedge clk); #1;
    chk("latency_n2", 128'(tvalid), 128'(1));
    chk("latency_grant", 128'(grant), 128'(1));
    wait_drain("latency");

    // Back-pressure toggling during a 4-beat packet
    expect_pkt(2, 5, 4);
    load(4'b0100, 5, 0, 4, 4);
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      tready = (i < 16) ? stall_pat[i] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    tready = 1'b1;
    wait_drain("stall");

    // Link drop mid-packet: current packet finishes, next waits for link
    expect_pkt(0, 6, 4);
    expect_pkt(1, 6, 4);
    load(4'b0011, 6, 0, 4, 4);
    for (int i = 0; i < 20 && !tvalid; i++) begin
      @(posedge clk); #1;
    end
    chk("lnk_start", 128'(tvalid), 128'(1));
    lnk = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("lnk_pending", 128'(sb.size()), 128'(4));
    chk("lnk_idle_valid", 128'(tvalid), 128'(0));
    chk("lnk_idle_grant", 128'(grant), 128'(0));
    lnk = 1'b1;
    wait_drain("lnk_resume");

    // Overflow on the 4-deep instance: 4 beats without tlast
    for (int b = 0; b < 4; b++) begin
      b_wr_tvalid = 2'b01;
      b_wr_tdata[DW-1:0] = mk_data(0, 8, b);
      b_wr_tkeep[KW-1:0] = 4'hF;
      b_wr_tuser[UW-1:0] = mk_user(0, 8, b);
      b_wr_tlast = 2'b00;
      @(posedge clk); #1;
    end
    b_wr_tvalid = 2'b00;
    chk("ovf_full", 128'(b_ch_full), 128'(2'b01));
    chk("ovf_not_yet", 128'(b_ovf), 128'(0));
    chk("ovf_tready_low", 128'(b_wr_tready), 128'(2'b10));
    @(posedge clk); #1;
    chk("ovf_err", 128'(b_ovf), 128'(2'b01));
    chk("ovf_flushed", 128'(b_ch_full), 128'(0));
    chk("ovf_tready_back", 128'(b_wr_tready), 128'(2'b11));
    b_wr_tvalid = 2'b01;
    b_wr_tdata[DW-1:0] = mk_data(0, 9, 0);
    b_wr_tlast = 2'b01;
    @(posedge clk); #1;
    b_wr_tvalid = 2'b00;
    b_wr_tlast = 2'b00;
    for (int i = 0; i < 10 && !b_tvalid; i++) begin
      @(posedge clk); #1;
    end
    chk("ovf_next_valid", 128'(b_tvalid), 128'(1));
    chk("ovf_next_data", 128'(b_tdata), 128'(mk_data(0, 9, 0)));
    chk("ovf_next_last", 128'(b_tlast), 128'(1));
    @(posedge clk); #1;
    chk("ovf_sticky", 128'(b_ovf), 128'(2'b01));
    chk("ovf_done", 128'(b_tvalid), 128'(0));

    // Reset during a stalled packet truncates it and discards stored beats
    tready = 1'b0;
    load(4'b0001, 7, 0, 4, 4);
    for (int i = 0; i < 20 && !tvalid; i++) begin
      @(posedge clk); #1;
    end
    chk("trunc_start", 128'(tvalid), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("trunc_valid", 128'(tvalid), 128'(0));
    chk("trunc_ovf_cleared", 128'(b_ovf), 128'(0));
    reset = 1'b0;
    tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("trunc_discard", 128'(tvalid), 128'(0));
    chk("trunc_wr_tready", 128'(wr_tready), 128'(4'hF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_rq_arbiter.md
USER_RQ_ARBITER -- requirements
Module: user_rq_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of requester-request source channels; legal range 1-8.
REQ-002 Parameter FIFO_DEPTH, default 16: beats stored per channel; power of two, minimum 4.
REQ-003 Parameter C_DATA_WIDTH, default 128: AXI-S data width.
REQ-004 Parameter KEEP_WIDTH, default C_DATA_WIDTH/32: tkeep width.
REQ-005 Parameter AXI4_RQ_TUSER_WIDTH, default 62: tuser width.
REQ-006 Port user_clk, input, 1: sole clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port user_lnk_up, input, 1: link-up qualifier for new grants.
REQ-009 Port wr_s_axis_rq_tdata, input, NUM_CH*C_DATA_WIDTH: per-channel data, channel i in slice i.
REQ-010 Port wr_s_axis_rq_tkeep, input, NUM_CH*KEEP_WIDTH: per-channel keep.
REQ-011 Port wr_s_axis_rq_tuser, input, NUM_CH*AXI4_RQ_TUSER_WIDTH: per-channel user.
REQ-012 Port wr_s_axis_rq_tlast, input, NUM_CH: per-channel end of packet.
REQ-013 Port wr_s_axis_rq_tvalid, input, NUM_CH: per-channel beat valid.
REQ-014 Port wr_s_axis_rq_tready, output, NUM_CH: per-channel ready, equal to not full.
REQ-015 Ports s_axis_rq_tdata/tkeep/tuser/tlast/tvalid, outputs, widths C_DATA_WIDTH/KEEP_WIDTH/AXI4_RQ_TUSER_WIDTH/1/1: merged request stream to the core.
REQ-016 Port s_axis_rq_tready, input, 1: core ready.
REQ-017 Port ch_full, output, NUM_CH: channel FIFO holds FIFO_DEPTH beats.
REQ-018 Port ch_ovf_err, output, NUM_CH: sticky oversize-packet error.
REQ-019 Port grant_ch, output, 3: index of the channel currently granted; 0 when idle.

Function
REQ-020 Each channel SHALL have a FIFO of FIFO_DEPTH beats, each beat storing {tdata, tkeep, tuser, tlast}; a beat is written when wr tvalid and wr tready are both high.
REQ-021 Each channel SHALL keep a beat count (0..FIFO_DEPTH) and a packet count (number of stored tlast beats); simultaneous write and read leave the beat count unchanged, and simultaneous write-last and read-last leave the packet count unchanged.
REQ-022 A channel SHALL be eligible only when its packet count is nonzero; partial packets are never granted.
REQ-023 The state machine SHALL have two states, IDLE and SEND.
REQ-024 IDLE: when user_lnk_up=1 and any channel is eligible, the arbiter SHALL grant the first eligible channel at or after rr_ptr (modulo NUM_CH), load grant_ch, and enter SEND the next cycle.
REQ-025 SEND: s_axis_rq_tvalid SHALL be 1 and s_axis_rq_* SHALL present the head beat of the granted FIFO (first-word fall-through); a beat is popped when s_axis_rq_tready=1.
REQ-026 On a popped beat with tlast=1, the arbiter SHALL return to IDLE and set rr_ptr to grant_ch+1 (wrapping to 0 after NUM_CH-1); the minimum gap between packets is one IDLE cycle.
REQ-027 s_axis_rq_tvalid SHALL be 0 in IDLE, and s_axis_rq_tdata/tkeep/tuser/tlast SHALL be 0 in IDLE.
REQ-028 The arbiter SHALL not deassert tvalid or change any tdata/tkeep/tuser/tlast bit while tvalid=1 and tready=0.
REQ-029 Latency: when a packet's last beat is written in cycle N into an otherwise idle block with link up, its first beat SHALL appear on s_axis_rq at cycle N+2.
REQ-030 If user_lnk_up falls during SEND, the current packet SHALL complete; no new grant is issued until user_lnk_up=1, and the stored data SHALL be retained.
REQ-031 If a channel's beat count reaches FIFO_DEPTH while its packet count is 0, ch_ovf_err[i] SHALL be set and the FIFO SHALL be flushed the next cycle (beat count 0); the error stays set until reset.
REQ-032 NUM_CH=1 SHALL degenerate to a packet-store-and-forward FIFO with grant_ch constantly 0.

Reset
REQ-033 While reset=1 on a clock edge, all FIFOs and packet counts SHALL be cleared, rr_ptr=0, state=IDLE, grant_ch=0, all s_axis_rq_* outputs=0, ch_full=0, ch_ovf_err=0, and wr_s_axis_rq_tready=all ones from the first cycle after reset.
REQ-034 A reset asserted during SEND SHALL truncate the outgoing packet, with tvalid=0 in the next cycle, and discard all stored beats.

Verification
REQ-035 NUM_CH=4: load one 3-beat packet into each of ch0-ch3 with tready=1 -> output order ch0, ch1, ch2, ch3, 3 beats each, one idle cycle between packets, and grant_ch 0,1,2,3.
REQ-036 After ch2 is served, load ch0 and ch3 at the same time -> ch3 is granted first, then ch0.
REQ-037 Write 2 beats into ch1 without tlast -> no output; on the tlast beat written in cycle N -> first beat appears at N+2.
REQ-038 Toggle tready randomly during a 4-beat packet -> output beats are held stable while stalled, there are no gaps or duplicates, and the data matches the input.
REQ-039 FIFO_DEPTH=4: write 4 beats into ch0 with no tlast -> ch_full[0]=1, then ch_ovf_err[0]=1 and the FIFO is empty the next cycle.
REQ-040 Drop user_lnk_up mid-packet -> the packet completes and no further grant is issued; raise user_lnk_up -> the pending packets drain.
